control_unit: RTL and testbench

- Fetch/decode/execute sequencer that sits directly upstream of the two-register file (`REG_SEL` mux, 2-way write decoder, R0/R1).
- Reads 8-bit instructions from program memory and drives `REG_SEL`, `REG_WR` and the register-input source select.
- Owns the program counter, the instruction register, the immediate register and the zero flag.
- Also strobes a temp-operand latch that feeds the ALU.

---
 rtl/control_unit_pkg.sv | 37 +++
 rtl/program_counter.sv | 35 +++
 rtl/control_unit.sv | 195 +++++++++++++++++++
 tb/tb_control_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// ---------------------------------------------------------------------------
// control_unit_pkg
// Shared definitions for the fetch/decode/execute sequencer:
//   - 3-bit opcode constants (instruction bits [7:5])
//   - FSM state encoding
//   - register-input source select codes driven on SRC_SEL
//   - ALU operation codes driven on ALU_OP
// No ports; imported by control_unit.
// ---------------------------------------------------------------------------
package control_unit_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_MOV = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_FETCH_IMM = 3'd2,
    ST_EXEC      = 3'd3,
    ST_WB        = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [1:0] SRC_IMM = 2'b00;
  localparam logic [1:0] SRC_TMP = 2'b01;
  localparam logic [1:0] SRC_ALU = 2'b10;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
// Program counter register with synchronous reset, load and increment.
// Ports:
//   CLK      - clock, rising edge
//   RST      - synchronous active-high reset, clears PC to 0
//   INC      - advance PC by one (wraps at 2^ADDR_WIDTH)
//   LOAD     - load LOAD_VAL into PC; takes priority over INC
//   LOAD_VAL - jump target
//   PC       - current program counter / memory address
// ---------------------------------------------------------------------------
module program_counter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INC,
  input  logic                  LOAD,
  input  logic [ADDR_WIDTH-1:0] LOAD_VAL,
  output logic [ADDR_WIDTH-1:0] PC
);

  // A jump and an increment never legitimately coincide, but if they do the
  // jump wins so control flow is never lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC <= '0;
    end else if (LOAD) begin
      PC <= LOAD_VAL;
    end else if (INC) begin
      PC <= PC + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Fetch/decode/execute sequencer for a two-register (R0/R1) datapath.
// Reads 8-bit instructions from program memory, owns PC, IR, IMM and the
// zero flag, and drives the register-file / ALU control lines.
// Ports:
//   CLK      - clock, rising edge
//   RST      - synchronous active-high reset
//   MEM_DATA - program memory word at address PC (combinational read)
//   ALU_ZERO - 1 when the current ALU result is zero
//   PC       - program counter / memory address
//   REG_SEL  - register-file read-mux and write-decoder select
//   REG_WR   - register-file write enable
//   SRC_SEL  - register input source: 00 IMM, 01 TMP latch, 10 ALU result
//   IMM      - immediate register
//   TMP_LD   - load the TMP operand latch from the register-file output
//   ALU_OP   - 0 add, 1 subtract
//   HALTED   - core stopped
// ---------------------------------------------------------------------------
module control_unit
  import control_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] MEM_DATA,
  input  logic                  ALU_ZERO,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  REG_SEL,
  output logic                  REG_WR,
  output logic [1:0]            SRC_SEL,
  output logic [DATA_WIDTH-1:0] IMM,
  output logic                  TMP_LD,
  output logic                  ALU_OP,
  output logic                  HALTED
);

  state_t     state;
  state_t     state_next;

  // Only the opcode, RD and RS fields of the instruction are kept; the low
  // three bits are reserved and never decoded.
  logic [2:0] ir_op;
  logic       ir_rd;
  logic       ir_rs;
  logic       z_flag;

  logic       pc_inc;
  logic       pc_load;

  logic       reg_sel_raw;
  logic       reg_wr_raw;
  logic [1:0] src_sel_raw;
  logic       tmp_ld_raw;
  logic       alu_op_raw;
  logic       halted_raw;

  program_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc (
    .CLK     (CLK),
    .RST     (RST),
    .INC     (pc_inc),
    .LOAD    (pc_load),
    .LOAD_VAL(MEM_DATA[ADDR_WIDTH-1:0]),
    .PC      (PC)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // IR is captured in FETCH, IMM in the second byte of LDI, and Z only on
  // the write-back of arithmetic instructions.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_op  <= OP_NOP;
      ir_rd  <= 1'b0;
      ir_rs  <= 1'b0;
      IMM    <= '0;
      z_flag <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir_op <= MEM_DATA[7:5];
          ir_rd <= MEM_DATA[4];
          ir_rs <= MEM_DATA[3];
        end
        ST_FETCH_IMM: begin
          if (ir_op == OP_LDI) begin
            IMM <= MEM_DATA;
          end
        end
        ST_WB: begin
          if ((ir_op == OP_ADD) || (ir_op == OP_SUB)) begin
            z_flag <= ALU_ZERO;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and control decode depend only on state, IR and Z, so no
  // output has a combinational path from MEM_DATA or ALU_ZERO.
  always_comb begin
    state_next  = state;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    reg_sel_raw = 1'b0;
    reg_wr_raw  = 1'b0;
    src_sel_raw = SRC_IMM;
    tmp_ld_raw  = 1'b0;
    alu_op_raw  = ALU_ADD;
    halted_raw  = 1'b0;
    case (state)
      ST_FETCH: begin
        pc_inc     = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (ir_op)
          OP_NOP:                state_next = ST_FETCH;
          OP_LDI, OP_JMP, OP_JZ: state_next = ST_FETCH_IMM;
          OP_MOV, OP_ADD, OP_SUB: state_next = ST_EXEC;
          OP_HLT:                state_next = ST_HALT;
        endcase
      end
      ST_FETCH_IMM: begin
        state_next = ST_FETCH;
        case (ir_op)
          OP_LDI: begin
            pc_inc     = 1'b1;
            state_next = ST_WB;
          end
          OP_JMP: pc_load = 1'b1;
          OP_JZ: begin
            // Not taken still has to step over the address byte.
            if (z_flag) begin
              pc_load = 1'b1;
            end else begin
              pc_inc = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
      ST_EXEC: begin
        reg_sel_raw = ir_rs;
        tmp_ld_raw  = 1'b1;
        state_next  = ST_WB;
      end
      ST_WB: begin
        reg_sel_raw = ir_rd;
        reg_wr_raw  = 1'b1;
        state_next  = ST_FETCH;
        case (ir_op)
          OP_LDI: src_sel_raw = SRC_IMM;
          OP_MOV: src_sel_raw = SRC_TMP;
          OP_ADD: src_sel_raw = SRC_ALU;
          OP_SUB: begin
            src_sel_raw = SRC_ALU;
            alu_op_raw  = ALU_SUB;
          end
          default: begin
          end
        endcase
      end
      ST_HALT: begin
        halted_raw = 1'b1;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // While RST is high every control line is forced inactive, so a reset that
  // lands in WB or EXEC can never write a register or load TMP.
  assign REG_SEL = reg_sel_raw & ~RST;
  assign REG_WR  = reg_wr_raw  & ~RST;
  assign SRC_SEL = RST ? SRC_IMM : src_sel_raw;
  assign TMP_LD  = tmp_ld_raw  & ~RST;
  assign ALU_OP  = alu_op_raw  & ~RST;
  assign HALTED  = halted_raw  & ~RST;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed testbench for control_unit: program memory, a two-register file,
// the TMP operand latch and the ALU are modelled around the DUT; expected
// values are hand-computed from the instruction cycle timing.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic       CLK;
  logic       RST;
  logic [7:0] MEM_DATA;
  logic       ALU_ZERO;
  logic [7:0] PC;
  logic       REG_SEL;
  logic       REG_WR;
  logic [1:0] SRC_SEL;
  logic [7:0] IMM;
  logic       TMP_LD;
  logic       ALU_OP;
  logic       HALTED;

  logic [7:0] mem [256];
  logic [7:0] r0;
  logic [7:0] r1;
  logic [7:0] tmp;
  logic [7:0] reg_out;
  logic [7:0] alu_res;
  logic [7:0] wdata;
  logic       clear_regs;

  int n_asserts;
  int n_fails;

  control_unit #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .MEM_DATA(MEM_DATA),
    .ALU_ZERO(ALU_ZERO),
    .PC      (PC),
    .REG_SEL (REG_SEL),
    .REG_WR  (REG_WR),
    .SRC_SEL (SRC_SEL),
    .IMM     (IMM),
    .TMP_LD  (TMP_LD),
    .ALU_OP  (ALU_OP),
    .HALTED  (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment around the sequencer: memory read, register file, TMP latch
  // and ALU.
  assign MEM_DATA = mem[PC];
  assign reg_out  = REG_SEL ? r1 : r0;
  assign alu_res  = ALU_OP ? (reg_out - tmp) : (reg_out + tmp);
  assign ALU_ZERO = (alu_res == 8'h00);

  always_comb begin
    wdata = 8'h00;
    case (SRC_SEL)
      2'b00:   wdata = IMM;
      2'b01:   wdata = tmp;
      2'b10:   wdata = alu_res;
      default: wdata = 8'h00;
    endcase
  end

  always @(posedge CLK) begin
    if (clear_regs) begin
      r0  <= 8'h00;
      r1  <= 8'h00;
      tmp <= 8'h00;
    end else begin
      if (TMP_LD) tmp <= reg_out;
      if (REG_WR) begin
        if (REG_SEL) r1 <= wdata;
        else         r0 <= wdata;
      end
    end
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Holds reset for two cycles and releases it on a falling edge; on return
  // the DUT is in cycle 0 (FETCH of address 0).
  task automatic startProgram(input logic clear);
    @(negedge CLK);
    RST        = 1'b1;
    clear_regs = clear;
    applyStimulus(2);
    RST        = 1'b0;
    clear_regs = 1'b0;
    #1;
  endtask

  initial begin
    int wr_count;
    n_asserts  = 0;
    n_fails    = 0;
    RST        = 1'b1;
    clear_regs = 1'b1;
    clearMem();

    // Reset from a running state, then LDI R0,5; LDI R1,3; HLT.
    mem[0] = 8'h20; mem[1] = 8'h05; mem[2] = 8'h30; mem[3] = 8'h03; mem[4] = 8'hE0;
    startProgram(1'b1);
    applyStimulus(2);
    RST = 1'b1;
    clear_regs = 1'b1;
    #1;
    checkOutput("rst_wr_gate", 32'(REG_WR), 32'd0);
    applyStimulus(2);
    checkOutput("rst_pc", 32'(PC), 32'd0);
    checkOutput("rst_wr", 32'(REG_WR), 32'd0);
    checkOutput("rst_halted", 32'(HALTED), 32'd0);
    checkOutput("rst_tmp_ld", 32'(TMP_LD), 32'd0);
    RST = 1'b0;
    clear_regs = 1'b0;
    #1;
    checkOutput("first_fetch_pc", 32'(PC), 32'd0);
    wr_count = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) applyStimulus(1);
      if (REG_WR) wr_count++;
      if (c == 3 || c == 7) checkOutput("ldi_wr_cycle", 32'(REG_WR), 32'd1);
    end
    checkOutput("ldi_wr_count", 32'(wr_count), 32'd2);
    checkOutput("ldi_r0", 32'(r0), 32'h05);
    checkOutput("ldi_r1", 32'(r1), 32'h03);
    checkOutput("ldi_halted", 32'(HALTED), 32'd1);
    checkOutput("ldi_halt_pc", 32'(PC), 32'd5);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1);
      checkOutput("halt_stable_pc", 32'(PC), 32'd5);
      checkOutput("halt_stable_flag", 32'(HALTED), 32'd1);
    end

    // SUB R0,R1; ADD R1,R0 after the two loads.
    clearMem();
    mem[0] = 8'h20; mem[1] = 8'h05; mem[2] = 8'h30; mem[3] = 8'h03;
    mem[4] = 8'h88; mem[5] = 8'h70; mem[6] = 8'hE0;
    startProgram(1'b1);
    applyStimulus(10);
    checkOutput("sub_exec_tmp_ld", 32'(TMP_LD), 32'd1);
    checkOutput("sub_exec_sel_rs", 32'(REG_SEL), 32'd1);
    checkOutput("sub_exec_no_wr", 32'(REG_WR), 32'd0);
    applyStimulus(1);
    checkOutput("sub_wb_wr", 32'(REG_WR), 32'd1);
    checkOutput("sub_wb_tmp_ld", 32'(TMP_LD), 32'd0);
    checkOutput("sub_wb_sel_rd", 32'(REG_SEL), 32'd0);
    checkOutput("sub_wb_src", 32'(SRC_SEL), 32'd2);
    checkOutput("sub_wb_alu_op", 32'(ALU_OP), 32'd1);
    applyStimulus(3);
    checkOutput("add_exec_tmp_ld", 32'(TMP_LD), 32'd1);
    checkOutput("add_exec_sel_rs", 32'(REG_SEL), 32'd0);
    applyStimulus(1);
    checkOutput("add_wb_wr", 32'(REG_WR), 32'd1);
    checkOutput("add_wb_sel_rd", 32'(REG_SEL), 32'd1);
    checkOutput("add_wb_alu_op", 32'(ALU_OP), 32'd0);
    applyStimulus(3);
    checkOutput("arith_halted", 32'(HALTED), 32'd1);
    checkOutput("arith_halt_pc", 32'(PC), 32'd7);
    checkOutput("arith_r0", 32'(r0), 32'h02);
    checkOutput("arith_r1", 32'(r1), 32'h05);

    // NOP; LDI R0,7; MOV R1,R0; ADD R0,R0; HLT.
    clearMem();
    mem[0] = 8'h00; mem[1] = 8'h20; mem[2] = 8'h07; mem[3] = 8'h50;
    mem[4] = 8'h60; mem[5] = 8'hE0;
    startProgram(1'b1);
    applyStimulus(5);
    checkOutput("nop_ldi_wb", 32'(REG_WR), 32'd1);
    applyStimulus(4);
    checkOutput("mov_wb_src", 32'(SRC_SEL), 32'd1);
    checkOutput("mov_wb_sel_rd", 32'(REG_SEL), 32'd1);
    applyStimulus(6);
    checkOutput("mix_not_yet_halted", 32'(HALTED), 32'd0);
    applyStimulus(1);
    checkOutput("mix_halted", 32'(HALTED), 32'd1);
    checkOutput("mix_halt_pc", 32'(PC), 32'd6);
    checkOutput("mov_r1", 32'(r1), 32'h07);
    checkOutput("add_self_r0", 32'(r0), 32'h0E);

    // JZ taken after a zero SUB.
    clearMem();
    mem[0] = 8'h20; mem[1] = 8'h03; mem[2] = 8'h30; mem[3] = 8'h03;
    mem[4] = 8'h88; mem[5] = 8'hC0; mem[6] = 8'h0A; mem[7] = 8'hE0;
    mem[10] = 8'hE0;
    startProgram(1'b1);
    applyStimulus(17);
    checkOutput("jz_taken_halted", 32'(HALTED), 32'd1);
    checkOutput("jz_taken_pc", 32'(PC), 32'h0B);
    checkOutput("jz_taken_r0", 32'(r0), 32'h00);

    // JZ not taken after a non-zero SUB.
    mem[3] = 8'h02;
    startProgram(1'b1);
    applyStimulus(17);
    checkOutput("jz_fall_halted", 32'(HALTED), 32'd1);
    checkOutput("jz_fall_pc", 32'(PC), 32'h08);
    checkOutput("jz_fall_r0", 32'(r0), 32'h01);

    // JMP to 0xFF, HLT there, PC wraps to 0.
    clearMem();
    mem[0] = 8'hA0; mem[1] = 8'hFF; mem[255] = 8'hE0;
    startProgram(1'b1);
    applyStimulus(3);
    checkOutput("jmp_target_pc", 32'(PC), 32'hFF);
    applyStimulus(2);
    checkOutput("jmp_wrap_halted", 32'(HALTED), 32'd1);
    checkOutput("jmp_wrap_pc", 32'(PC), 32'h00);

    // LDI at 0xFF whose immediate is at 0x00 (0xA0); then 0xFF at 0x01 is HLT.
    mem[255] = 8'h20;
    startProgram(1'b1);
    applyStimulus(6);
    checkOutput("ldi_wrap_wb", 32'(REG_WR), 32'd1);
    checkOutput("ldi_wrap_imm", 32'(IMM), 32'hA0);
    applyStimulus(3);
    checkOutput("ldi_wrap_halted", 32'(HALTED), 32'd1);
    checkOutput("ldi_wrap_pc", 32'(PC), 32'h02);
    checkOutput("ldi_wrap_r0", 32'(r0), 32'hA0);

    // Reset landing in the WB of LDI R0,0xAA.
    clearMem();
    mem[0] = 8'h20; mem[1] = 8'hAA; mem[2] = 8'hE0;
    startProgram(1'b1);
    applyStimulus(3);
    checkOutput("wb_before_rst", 32'(REG_WR), 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("wb_rst_wr", 32'(REG_WR), 32'd0);
    checkOutput("wb_rst_src", 32'(SRC_SEL), 32'd0);
    checkOutput("wb_rst_halted", 32'(HALTED), 32'd0);
    applyStimulus(1);
    startProgram(1'b0);
    checkOutput("wb_rst_r0_kept", 32'(r0), 32'h00);
    checkOutput("wb_rst_pc", 32'(PC), 32'd0);
    applyStimulus(4);
    checkOutput("wb_rst_refetch_r0", 32'(r0), 32'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
